// File: rtl/dwc_round_scheduler.sv
// dwc_round_scheduler: sequences one duplicate-with-compare round between two cores with arrival timeout, bounded retries and saturating fault statistics
module dwc_round_scheduler #(
  parameter int DATA_W = 32,
  parameter int TIMEOUT = 1024,
  parameter int MAX_RETRY = 2,
  parameter int CNT_W = 16,
  localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1,
  localparam int TW = $clog2(TIMEOUT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_a,
  input  logic              valid_a,
  input  logic [DATA_W-1:0] data_b,
  input  logic              valid_b,
  input  logic              irq_ack,
  output logic              busy,
  output logic              retry_req,
  output logic              interrupt_prompt,
  output logic              result_valid,
  output logic              isMatch,
  output logic [1:0]        fault_code,
  output logic [RW-1:0]     retry_cnt,
  output logic [CNT_W-1:0]  mismatch_cnt,
  output logic [CNT_W-1:0]  timeout_cnt
);

  typedef enum logic [2:0] {IDLE, COLLECT, COMPARE, RETRY, REPORT} state_t;

  state_t state, state_d;
  logic [DATA_W-1:0] lat_a, lat_b, lat_a_d, lat_b_d;
  logic got_a, got_b, got_a_d, got_b_d;
  logic [TW-1:0] timer, timer_d;
  logic [RW-1:0] retry_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_d, timeout_cnt_d;
  logic [1:0] fault_code_d;
  logic is_match_d, result_valid_d, interrupt_d, retry_req_d, busy_d;
  logic take_a, take_b, arrive, expire, equal, retry_ok, timed_out, enter_rep;

  // a strobe is only accepted while waiting for that core and only once per attempt
  assign take_a = (state == IDLE || state == COLLECT) && valid_a && !got_a;
  assign take_b = (state == IDLE || state == COLLECT) && valid_b && !got_b;
  assign arrive = take_a || take_b;
  assign expire = timer == TW'(TIMEOUT - 1);
  assign equal = lat_a == lat_b;
  assign retry_ok = retry_cnt < RW'(MAX_RETRY);
  // a late arrival on the expiry cycle beats the timeout
  assign timed_out = state == COLLECT && !arrive && expire;
  assign enter_rep = state_d == REPORT && state != REPORT;

  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_d;
  end

  // next-state decision for the round sequence
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = (take_a && take_b) ? COMPARE : arrive ? COLLECT : IDLE;
      COLLECT: state_d = arrive ? COMPARE : expire ? REPORT : COLLECT;
      COMPARE: state_d = (equal || !retry_ok) ? REPORT : RETRY;
      RETRY:   state_d = IDLE;
      REPORT:  state_d = irq_ack ? IDLE : REPORT;
      default: state_d = IDLE;
    endcase
  end

  // next values for latches, timer, counters and the registered outputs
  always_comb begin
    lat_a_d = take_a ? data_a : lat_a;
    lat_b_d = take_b ? data_b : lat_b;
    got_a_d = state_d != IDLE && (got_a || take_a);
    got_b_d = state_d != IDLE && (got_b || take_b);
    timer_d = state == COLLECT ? timer + TW'(1) : '0;
    retry_cnt_d = (state == REPORT && irq_ack) ? '0 :
                  (state == COMPARE && !equal && retry_ok) ? retry_cnt + RW'(1) : retry_cnt;
    mismatch_cnt_d = (state == COMPARE && !equal && mismatch_cnt != '1) ? mismatch_cnt + CNT_W'(1) : mismatch_cnt;
    timeout_cnt_d = (timed_out && timeout_cnt != '1) ? timeout_cnt + CNT_W'(1) : timeout_cnt;
    is_match_d = enter_rep ? (state == COMPARE && equal) : isMatch;
    fault_code_d = !enter_rep ? fault_code : (state == COLLECT) ? {1'b1, got_a} : {1'b0, !equal};
    result_valid_d = state_d == REPORT;
    interrupt_d = enter_rep;
    retry_req_d = state_d == RETRY;
    busy_d = state_d != IDLE;
  end

  // datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_a <= '0;
      lat_b <= '0;
      got_a <= 1'b0;
      got_b <= 1'b0;
      timer <= '0;
      retry_cnt <= '0;
      mismatch_cnt <= '0;
      timeout_cnt <= '0;
      isMatch <= 1'b0;
      fault_code <= 2'b00;
      result_valid <= 1'b0;
      interrupt_prompt <= 1'b0;
      retry_req <= 1'b0;
      busy <= 1'b0;
    end else begin
      lat_a <= lat_a_d;
      lat_b <= lat_b_d;
      got_a <= got_a_d;
      got_b <= got_b_d;
      timer <= timer_d;
      retry_cnt <= retry_cnt_d;
      mismatch_cnt <= mismatch_cnt_d;
      timeout_cnt <= timeout_cnt_d;
      isMatch <= is_match_d;
      fault_code <= fault_code_d;
      result_valid <= result_valid_d;
      interrupt_prompt <= interrupt_d;
      retry_req <= retry_req_d;
      busy <= busy_d;
    end
  end

endmodule

// File: tb/tb_dwc_round_scheduler.sv
// tb_dwc_round_scheduler: directed scenarios plus randomized rounds against a transaction-level model
module tb_dwc_round_scheduler;
  localparam int TO = 16;
  localparam int MR = 2;
  localparam int CW = 2;
  localparam int SAT = (1 << CW) - 1;

  logic clk = 0;
  logic reset = 0;
  logic [31:0] data_a = 0, data_b = 0;
  logic valid_a = 0, valid_b = 0, irq_ack = 0;
  logic busy, retry_req, interrupt_prompt, result_valid, is_match;
  logic [1:0] fault_code, retry_cnt, mismatch_cnt, timeout_cnt;

  int errors = 0;
  int checks = 0;
  int m_retry = 0, m_mis = 0, m_tmo = 0;

  dwc_round_scheduler #(.DATA_W(32), .TIMEOUT(TO), .MAX_RETRY(MR), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .data_a(data_a), .valid_a(valid_a), .data_b(data_b), .valid_b(valid_b),
    .irq_ack(irq_ack), .busy(busy), .retry_req(retry_req),
    .interrupt_prompt(interrupt_prompt), .result_valid(result_valid),
    .isMatch(is_match), .fault_code(fault_code), .retry_cnt(retry_cnt),
    .mismatch_cnt(mismatch_cnt), .timeout_cnt(timeout_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic strobe(input bit a, input bit b, input logic [31:0] da, input logic [31:0] db);
    valid_a = a;
    valid_b = b;
    if (a) data_a = da;
    if (b) data_b = db;
    tick();
    valid_a = 0;
    valid_b = 0;
  endtask

  // lat = edges after the last strobe's sampling edge until interrupt or retry is seen
  task automatic wait_event(output int lat, output bit hit_int, output bit hit_rty);
    lat = 0;
    while (!interrupt_prompt && !retry_req && lat < 3 * TO) begin
      tick();
      lat++;
    end
    hit_int = interrupt_prompt;
    hit_rty = retry_req;
  endtask

  task automatic ack;
    irq_ack = 1;
    tick();
    irq_ack = 0;
    m_retry = 0;
  endtask

  task automatic do_reset;
    valid_a = 0;
    valid_b = 0;
    irq_ack = 0;
    reset = 0;
    tick();
    reset = 1;
    m_retry = 0;
    m_mis = 0;
    m_tmo = 0;
  endtask

  function automatic int sat(input int v);
    return v > SAT ? SAT : v;
  endfunction

  // outcome of one attempt from the rules: fault code 0..3 for a report, 4 for a retry request
  function automatic int predict(input bit has_a, input bit has_b, input logic [31:0] a, input logic [31:0] b);
    if (!has_a) return 2;
    if (!has_b) return 3;
    if (a == b) return 0;
    return m_retry < MR ? 4 : 1;
  endfunction

  task automatic model_apply(input int k);
    if (k == 4) begin
      m_retry++;
      m_mis = sat(m_mis + 1);
    end else if (k == 1) m_mis = sat(m_mis + 1);
    else if (k == 2 || k == 3) m_tmo = sat(m_tmo + 1);
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, retry_req, interrupt_prompt, result_valid, is_match, fault_code, retry_cnt, mismatch_cnt, timeout_cnt} !== 13'd0)
      begin errors++; $display("FAIL reset_state: outputs=%b expected all zero", {busy, retry_req, interrupt_prompt, result_valid, is_match, fault_code, retry_cnt, mismatch_cnt, timeout_cnt}); end
    reset = 1;
    tick();
  endtask

  task automatic test_simultaneous;
    int lat; bit hi, hr;
    strobe(1, 1, 32'hDEADBEEF, 32'hDEADBEEF);
    checks++;
    if (busy !== 1) begin errors++; $display("FAIL sim_busy: busy=%b expected 1", busy); end
    wait_event(lat, hi, hr);
    checks++;
    if (lat != 1 || hi !== 1 || hr !== 0) begin errors++; $display("FAIL sim_latency: lat=%0d int=%b retry=%b expected 1 1 0", lat, hi, hr); end
    checks++;
    if ({result_valid, is_match, fault_code, mismatch_cnt} !== {1'b1, 1'b1, 2'b00, 2'd0})
      begin errors++; $display("FAIL sim_report: rv=%b match=%b fc=%b mis=%0d expected 1 1 00 0", result_valid, is_match, fault_code, mismatch_cnt); end
    tick();
    checks++;
    if (interrupt_prompt !== 0 || result_valid !== 1) begin errors++; $display("FAIL sim_hold: int=%b rv=%b expected 0 1", interrupt_prompt, result_valid); end
    strobe(1, 1, 32'h1, 32'h2);
    checks++;
    if ({busy, result_valid, is_match, fault_code} !== 5'b11100) begin errors++; $display("FAIL sim_report_strobe: busy=%b rv=%b match=%b fc=%b expected 1 1 1 00", busy, result_valid, is_match, fault_code); end
    ack();
    tick();
    checks++;
    if ({busy, result_valid, mismatch_cnt} !== 4'b0000) begin errors++; $display("FAIL sim_after_ack: busy=%b rv=%b mis=%0d expected 0 0 0", busy, result_valid, mismatch_cnt); end
  endtask

  task automatic test_ack_entry;
    int lat; bit hi, hr;
    strobe(1, 1, 32'h8, 32'h8);
    wait_event(lat, hi, hr);
    irq_ack = 1;
    tick();
    irq_ack = 0;
    checks++;
    if (hi !== 1 || result_valid !== 0 || busy !== 0) begin errors++; $display("FAIL ack_entry: int=%b rv=%b busy=%b expected 1 0 0", hi, result_valid, busy); end
  endtask

  task automatic test_repeat;
    int lat; bit hi, hr;
    strobe(1, 0, 32'h1, 32'h0);
    irq_ack = 1;
    tick();
    strobe(1, 0, 32'h2, 32'h0);
    tick();
    tick();
    irq_ack = 0;
    strobe(0, 1, 32'h0, 32'h1);
    wait_event(lat, hi, hr);
    checks++;
    if (lat != 1 || hi !== 1 || is_match !== 1 || fault_code !== 2'b00)
      begin errors++; $display("FAIL repeat_ignored: lat=%0d int=%b match=%b fc=%b expected 1 1 1 00", lat, hi, is_match, fault_code); end
    ack();
  endtask

  task automatic test_timeout;
    int lat; bit hi, hr;
    do_reset();
    strobe(0, 1, 32'h0, 32'h3);
    wait_event(lat, hi, hr);
    checks++;
    if (lat != TO || hi !== 1) begin errors++; $display("FAIL timeout_latency: lat=%0d int=%b expected %0d 1", lat, hi, TO); end
    checks++;
    if ({result_valid, is_match, fault_code, timeout_cnt} !== {1'b1, 1'b0, 2'b10, 2'd1})
      begin errors++; $display("FAIL timeout_report: rv=%b match=%b fc=%b tmo=%0d expected 1 0 10 1", result_valid, is_match, fault_code, timeout_cnt); end
    ack();
    strobe(1, 0, 32'h44, 32'h0);
    repeat (TO - 1) tick();
    strobe(0, 1, 32'h0, 32'h44);
    wait_event(lat, hi, hr);
    checks++;
    if (lat != 1 || hi !== 1 || fault_code !== 2'b00 || is_match !== 1 || timeout_cnt !== 2'd1)
      begin errors++; $display("FAIL expiry_arrival: lat=%0d int=%b fc=%b match=%b tmo=%0d expected 1 1 00 1 1", lat, hi, fault_code, is_match, timeout_cnt); end
    ack();
  endtask

  task automatic test_retry;
    int lat; bit hi, hr;
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      strobe(1, 1, 32'h5, 32'h6);
      wait_event(lat, hi, hr);
      if (i < 3) begin
        checks++;
        if (hr !== 1 || hi !== 0 || lat != 1 || retry_cnt !== 2'(i) || busy !== 1)
          begin errors++; $display("FAIL retry_%0d: retry=%b int=%b lat=%0d rcnt=%0d busy=%b expected 1 0 1 %0d 1", i, hr, hi, lat, retry_cnt, busy, i); end
        tick();
      end
    end
    checks++;
    if (hi !== 1 || {is_match, fault_code, retry_cnt, mismatch_cnt} !== {1'b0, 2'b01, 2'd2, 2'd3})
      begin errors++; $display("FAIL retry_exhausted: int=%b match=%b fc=%b rcnt=%0d mis=%0d expected 1 0 01 2 3", hi, is_match, fault_code, retry_cnt, mismatch_cnt); end
    ack();
    checks++;
    if (retry_cnt !== 2'd0 || result_valid !== 0) begin errors++; $display("FAIL retry_cleared: rcnt=%0d rv=%b expected 0 0", retry_cnt, result_valid); end
  endtask

  task automatic test_match_after_retry;
    int lat; bit hi, hr;
    do_reset();
    strobe(1, 1, 32'h5, 32'h6);
    wait_event(lat, hi, hr);
    strobe(1, 1, 32'h9, 32'h9);
    checks++;
    if (hr !== 1 || busy !== 0) begin errors++; $display("FAIL retry_strobe_ignored: retry=%b busy=%b expected 1 0", hr, busy); end
    strobe(1, 1, 32'h7, 32'h7);
    wait_event(lat, hi, hr);
    checks++;
    if (hi !== 1 || {is_match, fault_code, retry_cnt, mismatch_cnt} !== {1'b1, 2'b00, 2'd1, 2'd1})
      begin errors++; $display("FAIL match_after_retry: int=%b match=%b fc=%b rcnt=%0d mis=%0d expected 1 1 00 1 1", hi, is_match, fault_code, retry_cnt, mismatch_cnt); end
    ack();
  endtask

  task automatic test_reset_mid;
    int lat, ints; bit hi, hr;
    do_reset();
    strobe(1, 0, 32'h3, 32'h0);
    tick();
    #2 reset = 0;
    #1;
    checks++;
    if ({busy, retry_req, interrupt_prompt, result_valid, is_match, fault_code, retry_cnt, mismatch_cnt, timeout_cnt} !== 13'd0)
      begin errors++; $display("FAIL reset_collect: outputs=%b expected all zero", {busy, retry_req, interrupt_prompt, result_valid, is_match, fault_code, retry_cnt, mismatch_cnt, timeout_cnt}); end
    @(negedge clk) reset = 1;
    ints = 0;
    repeat (TO + 4) begin tick(); ints += interrupt_prompt; end
    checks++;
    if (ints != 0 || busy !== 0) begin errors++; $display("FAIL reset_collect_silent: interrupts=%0d busy=%b expected 0 0", ints, busy); end
    strobe(1, 0, 32'h3, 32'h0);
    wait_event(lat, hi, hr);
    tick();
    #2 reset = 0;
    #1;
    checks++;
    if ({busy, retry_req, interrupt_prompt, result_valid, is_match, fault_code, retry_cnt, mismatch_cnt, timeout_cnt} !== 13'd0)
      begin errors++; $display("FAIL reset_report: outputs=%b expected all zero", {busy, retry_req, interrupt_prompt, result_valid, is_match, fault_code, retry_cnt, mismatch_cnt, timeout_cnt}); end
    @(negedge clk) reset = 1;
    ints = 0;
    repeat (5) begin tick(); ints += interrupt_prompt; end
    checks++;
    if (ints != 0 || result_valid !== 0) begin errors++; $display("FAIL reset_report_silent: interrupts=%0d rv=%b expected 0 0", ints, result_valid); end
  endtask

  task automatic test_saturation;
    int lat; bit hi, hr;
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      strobe(i % 2 == 1, i % 2 == 0, 32'h1, 32'h1);
      wait_event(lat, hi, hr);
      checks++;
      if (hi !== 1 || timeout_cnt !== 2'(i > 3 ? 3 : i))
        begin errors++; $display("FAIL timeout_sat_%0d: int=%b tmo=%0d expected 1 %0d", i, hi, timeout_cnt, i > 3 ? 3 : i); end
      ack();
    end
  endtask

  task automatic test_random;
    int kind, d, lat, k, exp_lat, gap;
    bit a_first, has_a, has_b, hi, hr;
    logic [31:0] va, vb;
    do_reset();
    for (int r = 0; r < 40; r++) begin
      kind = $urandom_range(0, 9);
      a_first = 1'($urandom_range(0, 1));
      va = $urandom;
      vb = $urandom_range(0, 1) ? va : $urandom;
      has_a = kind >= 2 || a_first;
      has_b = kind >= 2 || !a_first;
      k = predict(has_a, has_b, va, vb);
      if (kind >= 2 && kind <= 4) strobe(1, 1, va, vb);
      else begin
        strobe(a_first, !a_first, va, vb);
        if (kind >= 5) begin
          d = $urandom_range(1, TO);
          for (int j = 1; j < d; j++)
            if (j == 1 && d > 2 && $urandom_range(0, 1) == 1) strobe(a_first, !a_first, ~va, ~vb);
            else tick();
          strobe(!a_first, a_first, va, vb);
        end
      end
      wait_event(lat, hi, hr);
      exp_lat = (k == 2 || k == 3) ? TO : 1;
      model_apply(k);
      checks++;
      if (lat != exp_lat || hi !== (k != 4) || hr !== (k == 4))
        begin errors++; $display("FAIL rnd%0d_event: lat=%0d int=%b retry=%b expected %0d %b %b", r, lat, hi, hr, exp_lat, k != 4, k == 4); end
      checks++;
      if ({retry_cnt, mismatch_cnt, timeout_cnt} !== {2'(m_retry), 2'(m_mis), 2'(m_tmo)})
        begin errors++; $display("FAIL rnd%0d_counts: rcnt=%0d mis=%0d tmo=%0d expected %0d %0d %0d", r, retry_cnt, mismatch_cnt, timeout_cnt, m_retry, m_mis, m_tmo); end
      if (k == 4) tick();
      else begin
        checks++;
        if ({result_valid, is_match, fault_code} !== {1'b1, k == 0, 2'(k)})
          begin errors++; $display("FAIL rnd%0d_report: rv=%b match=%b fc=%b expected 1 %b %0d", r, result_valid, is_match, fault_code, k == 0, k); end
        gap = $urandom_range(0, 2);
        repeat (gap) tick();
        ack();
        checks++;
        if (result_valid !== 0 || retry_cnt !== 2'd0) begin errors++; $display("FAIL rnd%0d_ack: rv=%b rcnt=%0d expected 0 0", r, result_valid, retry_cnt); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_ack_entry();
    test_repeat();
    test_timeout();
    test_retry();
    test_match_after_retry();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
